header_inserter: RTL and testbench

HEADER_INSERTER -- requirements
Module: header_inserter

---
 rtl/header_inserter_pkg.sv | 31 +++
 rtl/avalon_st_if.sv | 35 +++
 rtl/header_inserter.sv | 117 +++++++++++
 tb/tb_header_inserter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/header_inserter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : header_inserter_pkg                                        |
// | Purpose : Shared stream package. Holds the state types of the header |
// |           insertion and header removal blocks and a size helper.     |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package header_inserter_pkg;

   // Header insertion block states
   typedef enum logic [1:0] {
      IDLE_ST   = 2'd0,
      HEADER_ST = 2'd1,
      DATA_ST   = 2'd2
   } hdr_ins_st_t;

   // Header removal block states
   typedef enum logic [1:0] {
      REM_IDLE_ST  = 2'd0,
      REM_STRIP_ST = 2'd1,
      REM_DATA_ST  = 2'd2
   } hdr_rem_st_t;

   // Width of a beat counter able to hold 0..n_beats
   function automatic int beat_cnt_width(input int n_beats);
      return $clog2(n_beats) + 1;
   endfunction

endpackage : header_inserter_pkg
`default_nettype wire

// File: rtl/avalon_st_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : avalon_st_if                                               |
// | Purpose : Avalon-ST style streaming interface (data/valid/ready with |
// |           packet framing).                                           |
// | Ports   : master - drives data, valid, startofpacket, endofpacket    |
// |           slave  - drives ready                                      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface avalon_st_if #(
   parameter int DATA_WIDTH = 128
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;
   logic                  startofpacket;
   logic                  endofpacket;

   modport master (
      output data,
      output valid,
      output startofpacket,
      output endofpacket,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  startofpacket,
      input  endofpacket,
      output ready
   );
endinterface : avalon_st_if
`default_nettype wire

// File: rtl/header_inserter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : header_inserter                                            |
// | Purpose : Prepends a HEADER_SIZE-bit header, sent MSB slice first as |
// |           HEADER_SIZE/DATA_WIDTH beats, in front of each payload     |
// |           packet. The payload then passes through combinationally.   |
// | Ports   : clk, rst (async, active high)                              |
// |           header_data/header_valid/header_ready - header handshake   |
// |           data_in  (slave)  - payload stream                         |
// |           data_out (master) - header beats followed by payload       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module header_inserter
   import header_inserter_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int HEADER_SIZE = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [HEADER_SIZE-1:0] header_data,
   input  logic                   header_valid,
   output logic                   header_ready,
   avalon_st_if.slave             data_in,
   avalon_st_if.master            data_out
);

   localparam int N     = HEADER_SIZE / DATA_WIDTH;
   localparam int CNT_W = beat_cnt_width(N);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N - 1);

   generate
      if ((HEADER_SIZE % DATA_WIDTH) != 0 || HEADER_SIZE < DATA_WIDTH) begin : g_bad_size
         $error("header_inserter: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
      end
   endgenerate

   hdr_ins_st_t            r_state;
   hdr_ins_st_t            w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [HEADER_SIZE-1:0] r_header;
   logic [HEADER_SIZE-1:0] w_hdr_shift;

   // Shifting the current slice to the top keeps the beat select free of
   // variable part-select bounds.
   always_comb begin
      w_hdr_shift = r_header << (DATA_WIDTH * 32'(r_cnt));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE_ST;
         r_cnt    <= '0;
         r_header <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE_ST: begin
               if (header_valid) begin
                  r_header <= header_data;
                  r_cnt    <= '0;
               end
            end
            HEADER_ST: begin
               if (data_out.ready && (r_cnt != LAST_BEAT)) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced inactive for the whole reset window, including the
   // cycle where reset is applied asynchronously.
   always_comb begin
      w_state_nxt            = r_state;
      header_ready           = 1'b0;
      data_in.ready          = 1'b0;
      data_out.valid         = 1'b0;
      data_out.data          = w_hdr_shift[HEADER_SIZE-1 -: DATA_WIDTH];
      data_out.startofpacket = 1'b0;
      data_out.endofpacket   = 1'b0;
      if (!rst) begin
         case (r_state)
            IDLE_ST: begin
               header_ready = 1'b1;
               if (header_valid) begin
                  w_state_nxt = HEADER_ST;
               end
            end
            HEADER_ST: begin
               data_out.valid         = 1'b1;
               data_out.startofpacket = (r_cnt == '0);
               if (data_out.ready && (r_cnt == LAST_BEAT)) begin
                  w_state_nxt = DATA_ST;
               end
            end
            DATA_ST: begin
               // Payload sop is ignored; the packet sop was the first header beat.
               data_out.valid       = data_in.valid;
               data_in.ready        = data_out.ready;
               data_out.data        = data_in.data;
               data_out.endofpacket = data_in.endofpacket;
               if (data_in.valid && data_out.ready && data_in.endofpacket) begin
                  w_state_nxt = IDLE_ST;
               end
            end
            default: begin
               w_state_nxt = IDLE_ST;
            end
         endcase
      end
   end

endmodule : header_inserter
`default_nettype wire

// File: tb/tb_header_inserter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_header_inserter                                         |
// | Purpose : Self-checking bench for header_inserter: vector table,     |
// |           directed multi-cycle sequences, and randomized packets     |
// |           checked against a beat-queue reference model.             |
// | Ports   : none                                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_header_inserter;

   localparam int DW = 128;
   localparam int HS = 256;
   localparam int N  = HS / DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main DUT (N = 2)
   logic [HS-1:0] header_data;
   logic          header_valid;
   logic          header_ready;
   avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
   avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

   header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) dut (
      .clk          (clk),
      .rst          (rst),
      .header_data  (header_data),
      .header_valid (header_valid),
      .header_ready (header_ready),
      .data_in      (in_if),
      .data_out     (out_if)
   );

   // Second DUT with a single-beat header (N = 1)
   logic [DW-1:0] header_data1;
   logic          header_valid1;
   logic          header_ready1;
   avalon_st_if #(.DATA_WIDTH(DW)) in1_if ();
   avalon_st_if #(.DATA_WIDTH(DW)) out1_if ();

   header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(DW)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .header_data  (header_data1),
      .header_valid (header_valid1),
      .header_ready (header_ready1),
      .data_in      (in1_if),
      .data_out     (out1_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic hv, input logic [HS-1:0] hdr, input logic iv,
                        input logic [DW-1:0] id, input logic isop, input logic ieop,
                        input logic ordy);
      header_valid         = hv;
      header_data          = hdr;
      in_if.valid          = iv;
      in_if.data           = id;
      in_if.startofpacket  = isop;
      in_if.endofpacket    = ieop;
      out_if.ready         = ordy;
   endtask

   typedef struct {
      logic          hv;
      logic          iv;
      logic [DW-1:0] id;
      logic          isop;
      logic          ieop;
      logic          ordy;
      logic          ev;
      logic [DW-1:0] ed;
      logic          esop;
      logic          eeop;
      logic          ehr;
      logic          eir;
   } vec_t;

   function automatic vec_t mk(input logic hv, input logic iv, input logic [DW-1:0] id,
                               input logic isop, input logic ieop, input logic ordy,
                               input logic ev, input logic [DW-1:0] ed, input logic esop,
                               input logic eeop, input logic ehr, input logic eir);
      vec_t v;
      v.hv = hv; v.iv = iv; v.id = id; v.isop = isop; v.ieop = ieop; v.ordy = ordy;
      v.ev = ev; v.ed = ed; v.esop = esop; v.eeop = eeop; v.ehr = ehr; v.eir = eir;
      return v;
   endfunction

   typedef struct {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
   } beat_t;

   beat_t exp_q[$];

   initial begin
      vec_t          vecs[$];
      logic [HS-1:0] h;
      logic [HS-1:0] h2;
      logic [DW-1:0] a, b, c, d;
      beat_t         e;

      h = {128'h1, 128'h2};
      a = 128'hAAAA_0001;
      b = 128'hBBBB_0002;
      c = 128'hCCCC_0003;
      d = 128'hDDDD_0004;

      drive(1'b1, h, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      header_valid1       = 1'b0;
      header_data1        = '0;
      in1_if.valid        = 1'b0;
      in1_if.data         = '0;
      in1_if.startofpacket = 1'b0;
      in1_if.endofpacket  = 1'b0;
      out1_if.ready       = 1'b1;

      // ---------------- reset state ----------------
      repeat (3) next_cycle();
      chk("rst_hready", header_ready, 1'b0);
      chk("rst_valid", out_if.valid, 1'b0);
      chk("rst_sop", out_if.startofpacket, 1'b0);
      chk("rst_eop", out_if.endofpacket, 1'b0);
      chk("rst_in_ready", in_if.ready, 1'b0);
      drive(1'b0, h, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      #1;
      chk("post_rst_hready", header_ready, 1'b1);
      next_cycle();

      // ---------------- vector table ----------------
      // two-beat header, 3-beat payload, ready always high
      vecs.push_back(mk(1, 0, '0, 0, 0, 1,  0, '0,     0, 0, 1, 0));
      vecs.push_back(mk(0, 1, a,  1, 0, 1,  1, 128'h1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, a,  1, 0, 1,  1, 128'h2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, a,  1, 0, 1,  1, a,      0, 0, 0, 1));
      vecs.push_back(mk(0, 1, b,  0, 0, 1,  1, b,      0, 0, 0, 1));
      vecs.push_back(mk(0, 1, c,  0, 1, 1,  1, c,      0, 1, 0, 1));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  0, '0,     0, 0, 1, 0));
      // same packet with output ready toggling
      vecs.push_back(mk(1, 0, '0, 0, 0, 1,  0, '0,     0, 0, 1, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 0,  1, 128'h1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  1, 128'h1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 0,  1, 128'h2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  1, 128'h2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, a,  1, 0, 0,  1, a,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, a,  1, 0, 1,  1, a,      0, 0, 0, 1));
      vecs.push_back(mk(0, 1, b,  0, 0, 0,  1, b,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, b,  0, 0, 1,  1, b,      0, 0, 0, 1));
      vecs.push_back(mk(0, 1, c,  0, 1, 0,  1, c,      0, 1, 0, 0));
      vecs.push_back(mk(0, 1, c,  0, 1, 1,  1, c,      0, 1, 0, 1));
      vecs.push_back(mk(0, 0, '0, 0, 0, 0,  0, '0,     0, 0, 1, 0));
      // single-beat payload carrying both sop and eop
      vecs.push_back(mk(1, 0, '0, 0, 0, 1,  0, '0,     0, 0, 1, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  1, 128'h1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  1, 128'h2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, d,  1, 1, 1,  1, d,      0, 1, 0, 1));
      vecs.push_back(mk(0, 0, '0, 0, 0, 1,  0, '0,     0, 0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].hv, h, vecs[i].iv, vecs[i].id, vecs[i].isop, vecs[i].ieop, vecs[i].ordy);
         #1;
         chk($sformatf("vec%0d_valid", i), out_if.valid, vecs[i].ev);
         chk($sformatf("vec%0d_hready", i), header_ready, vecs[i].ehr);
         chk($sformatf("vec%0d_in_ready", i), in_if.ready, vecs[i].eir);
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_data", i), out_if.data, vecs[i].ed);
            chk($sformatf("vec%0d_sop", i), out_if.startofpacket, vecs[i].esop);
            chk($sformatf("vec%0d_eop", i), out_if.endofpacket, vecs[i].eeop);
         end
         next_cycle();
      end

      // ---------------- second header held pending during DATA ----------------
      h2 = {128'h2222_0001, 128'h2222_0002};
      drive(1, h, 0, '0, 0, 0, 1); #1;
      chk("pend_accept1", header_ready, 1'b1);
      next_cycle();
      drive(0, h, 0, '0, 0, 0, 1); next_cycle();
      drive(0, h, 0, '0, 0, 0, 1); next_cycle();
      drive(1, h2, 1, a, 0, 0, 1); #1;
      chk("pend_hready_data", header_ready, 1'b0);
      chk("pend_data_a", out_if.data, a);
      next_cycle();
      drive(1, h2, 1, b, 0, 1, 1); #1;
      chk("pend_hready_eop", header_ready, 1'b0);
      chk("pend_eop", out_if.endofpacket, 1'b1);
      next_cycle();
      drive(1, h2, 0, '0, 0, 0, 1); #1;
      chk("pend_hready_idle", header_ready, 1'b1);
      next_cycle();
      drive(0, h2, 0, '0, 0, 0, 1); #1;
      chk("pend_h2_data", out_if.data, h2[HS-1 -: DW]);
      chk("pend_h2_sop", out_if.startofpacket, 1'b1);
      next_cycle();
      drive(0, h2, 0, '0, 0, 0, 1); next_cycle();
      drive(0, h2, 1, c, 0, 1, 1); #1;
      chk("pend_p2_eop_data", out_if.data, c);
      next_cycle();

      // ---------------- reset pulse mid-packet ----------------
      drive(1, h, 0, '0, 0, 0, 1); next_cycle();
      drive(0, h, 0, '0, 0, 0, 1); next_cycle();
      rst = 1'b1; #1;
      chk("midrst_valid", out_if.valid, 1'b0);
      chk("midrst_hready", header_ready, 1'b0);
      chk("midrst_in_ready", in_if.ready, 1'b0);
      next_cycle();
      rst = 1'b0; #1;
      chk("midrst_release_valid", out_if.valid, 1'b0);
      chk("midrst_release_hready", header_ready, 1'b1);
      drive(1, h2, 0, '0, 0, 0, 1);
      next_cycle();
      drive(0, h2, 0, '0, 0, 0, 1); #1;
      chk("midrst_new_valid", out_if.valid, 1'b1);
      chk("midrst_new_data", out_if.data, h2[HS-1 -: DW]);
      chk("midrst_new_sop", out_if.startofpacket, 1'b1);
      next_cycle();
      drive(0, h2, 0, '0, 0, 0, 1); next_cycle();
      drive(0, h2, 1, d, 0, 1, 1); next_cycle();
      drive(0, h2, 0, '0, 0, 0, 1); next_cycle();

      // ---------------- single-beat header (N = 1) ----------------
      header_valid1 = 1'b1;
      header_data1  = 128'h1111_2222_3333_4444;
      in1_if.valid  = 1'b1;
      in1_if.data   = 128'hE0E0;
      in1_if.endofpacket = 1'b1;
      #1;
      chk("n1_hready", header_ready1, 1'b1);
      next_cycle();
      header_valid1 = 1'b0;
      #1;
      chk("n1_hdr_valid", out1_if.valid, 1'b1);
      chk("n1_hdr_data", out1_if.data, 128'h1111_2222_3333_4444);
      chk("n1_hdr_sop", out1_if.startofpacket, 1'b1);
      chk("n1_hdr_in_ready", in1_if.ready, 1'b0);
      next_cycle();
      chk("n1_pay_data", out1_if.data, 128'hE0E0);
      chk("n1_pay_eop", out1_if.endofpacket, 1'b1);
      chk("n1_pay_sop", out1_if.startofpacket, 1'b0);
      chk("n1_pay_in_ready", in1_if.ready, 1'b1);
      next_cycle();
      in1_if.valid = 1'b0;
      #1;
      chk("n1_back_idle", header_ready1, 1'b1);

      // ---------------- randomized packets vs. beat-queue model ----------------
      for (int p = 0; p < 40; p++) begin
         logic [HS-1:0] rh;
         logic [DW-1:0] pay[4];
         int            len, pidx, cycles;
         logic          pending, hs_h, hs_i, hs_o;

         for (int w = 0; w < HS / 32; w++) rh[w*32 +: 32] = $urandom;
         len = $urandom_range(1, 4);
         for (int j = 0; j < 4; j++) pay[j] = {$urandom, $urandom, $urandom, $urandom};

         for (int j = 0; j < N; j++) begin
            e.data = rh[HS-1-j*DW -: DW];
            e.sop  = (j == 0);
            e.eop  = 1'b0;
            exp_q.push_back(e);
         end
         for (int j = 0; j < len; j++) begin
            e.data = pay[j];
            e.sop  = 1'b0;
            e.eop  = (j == len - 1);
            exp_q.push_back(e);
         end

         pending = 1'b1;
         pidx    = 0;
         cycles  = 0;
         while ((pending || pidx < len || exp_q.size() != 0) && cycles < 200) begin
            drive(pending, rh,
                  (pidx < len) && ($urandom_range(0, 3) != 0),
                  (pidx < len) ? pay[pidx] : '0,
                  1'($urandom_range(0, 1)),
                  (pidx == len - 1),
                  ($urandom_range(0, 2) != 0));
            #1;
            hs_h = header_valid && header_ready;
            hs_i = in_if.valid && in_if.ready;
            hs_o = out_if.valid && out_if.ready;
            if (hs_o) begin
               if (exp_q.size() == 0) begin
                  chk($sformatf("rand%0d_extra_beat", p), 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("rand%0d_data", p), out_if.data, e.data);
                  chk($sformatf("rand%0d_sop", p), out_if.startofpacket, e.sop);
                  chk($sformatf("rand%0d_eop", p), out_if.endofpacket, e.eop);
               end
            end
            next_cycle();
            if (hs_h) pending = 1'b0;
            if (hs_i) pidx++;
            cycles++;
         end
         chk($sformatf("rand%0d_timeout", p), (cycles >= 200), 1'b0);
         chk($sformatf("rand%0d_left", p), exp_q.size(), 0);
         exp_q.delete();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_header_inserter
`default_nettype wire
